// File: rtl/multicycle_alu_if.sv
// Operand/result handshake bundle between the issuing datapath and the multicycle ALU.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  result_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output result_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: ADD/SUB/OR in one cycle, SLL/SRL iterate one bit per cycle
// behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic              clk,
  input logic              reset,
  multicycle_alu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    left_q, left_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;

  logic                    accept;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH-1:0]   acc_step;

  assign accept   = bus.start_i && (state_q != SHIFT);
  assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];
  assign acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          state_d  = DONE;
        end
      end
      default: begin
        if (accept) begin
          state_d = DONE;
          case (bus.ALU_Operation_i)
            OP_SUB:  result_d = bus.A_i - bus.B_i;
            OP_OR:   result_d = bus.A_i | bus.B_i;
            OP_SLL, OP_SRL: begin
              result_d = bus.A_i;
              // Zero shift amount completes immediately with A unchanged.
              if (shamt != '0) begin
                result_d = result_q;
                acc_d    = bus.A_i;
                cnt_d    = shamt;
                left_d   = (bus.ALU_Operation_i == OP_SLL);
                state_d  = SHIFT;
              end
            end
            default: result_d = bus.A_i + bus.B_i;
          endcase
          if (state_d == DONE) zero_d = (result_d == '0);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.busy_o   = (state_q == SHIFT);
  assign bus.done_o   = (state_q == DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed cases then random ops vs. an arithmetic model.
module tb_multicycle_alu;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.DATA_WIDTH(DW)) bus ();
  multicycle_alu #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    int            neg;
  } exp_t;

  exp_t q[$];
  int   ncyc = 0;
  int   last_done = 0;
  int   busy_lo = 1, busy_hi = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (negedge %0d)", nm, act, exp, ncyc);
    end
  endtask

  function automatic logic [DW-1:0] model(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      4'd1: return a - b;
      4'd2: return a | b;
      4'd3: return a << b[4:0];
      4'd4: return a >> b[4:0];
      default: return a + b;
    endcase
  endfunction

  // Monitor: counts negedges, checks busy window and pops on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (reset) begin
      chk("busy", {31'b0, bus.busy_o}, {31'b0, (ncyc >= busy_lo && ncyc <= busy_hi)});
      if (bus.done_o) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("done_cycle", ncyc, e.neg);
          chk("result", bus.result_o, e.res);
          chk("zero", {31'b0, bus.zero_o}, {31'b0, e.z});
        end
      end else if (q.size() > 0 && q[0].neg < ncyc) begin
        e = q.pop_front();
        chk("missed_done", ncyc, e.neg);
      end
    end
  end

  task automatic issue(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t e;
    int   n;
    while (ncyc < last_done) begin @(negedge clk); #1; end
    bus.start_i = 1'b1; bus.ALU_Operation_i = op; bus.A_i = a; bus.B_i = b;
    n = (op == 4'd3 || op == 4'd4) ? int'(b[4:0]) : 0;
    e.res = model(op, a, b);
    e.z   = (e.res == '0);
    e.neg = ncyc + 1 + n;
    q.push_back(e);
    last_done = e.neg;
    busy_lo = ncyc + 1;
    busy_hi = ncyc + n;
    @(negedge clk); #1;
    bus.start_i = 1'b0;
    bus.A_i = $urandom; bus.B_i = $urandom; bus.ALU_Operation_i = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 100) begin @(negedge clk); #1; t++; end
    if (q.size() > 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.ALU_Operation_i = 4'd0; bus.A_i = '0; bus.B_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_result", bus.result_o, 0);
    chk("rst_zero", {31'b0, bus.zero_o}, 0);
    chk("rst_busy", {31'b0, bus.busy_o}, 0);
    chk("rst_done", {31'b0, bus.done_o}, 0);
    reset = 1'b1;
    @(negedge clk); #1;

    issue(4'd0, 32'd5, 32'd7);
    issue(4'd1, 32'd3, 32'd5);
    issue(4'd1, 32'd9, 32'd9);
    issue(4'd3, 32'd1, 32'd31);
    issue(4'd4, 32'h8000_0000, 32'h24);
    issue(4'd3, 32'hDEAD_BEEF, 32'd0);
    issue(4'd2, 32'hF0, 32'h0F);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    issue(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFE0);
    drain();

    // ADD pulsed mid-shift must be ignored and the shift keep its captured operands.
    issue(4'd4, 32'h1234_5678, 32'd10);
    @(negedge clk); #1;
    bus.start_i = 1'b1; bus.ALU_Operation_i = 4'd0; bus.A_i = 32'h1111; bus.B_i = 32'h2222;
    @(negedge clk); #1;
    bus.start_i = 1'b0; bus.A_i = 32'hAAAA_5555; bus.B_i = 32'h5;
    drain();
    repeat (3) @(negedge clk);
    #1;

    // Reset in the middle of a long shift discards it.
    issue(4'd3, 32'h0000_00FF, 32'd20);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_result", bus.result_o, 0);
    chk("midrst_zero", {31'b0, bus.zero_o}, 0);
    chk("midrst_busy", {31'b0, bus.busy_o}, 0);
    chk("midrst_done", {31'b0, bus.done_o}, 0);
    q.delete();
    busy_hi = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    last_done = ncyc;
    repeat (25) @(negedge clk);
    #1;
    issue(4'd0, 32'd2, 32'd2);
    drain();

    for (int i = 0; i < 60; i++) begin
      logic [3:0]    op;
      logic [DW-1:0] a, b;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = '0;
      issue(op, a, b);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
